// File: rtl/shift_reg_pkg.sv
// Shared mode encoding for the universal shift register.
// Imported by the register top and its word counter.
package shift_reg_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_word_cnt.sv
// Modulo-WIDTH shift counter with a one-cycle word_done pulse.
// restart wins over step; done is only ever a single-cycle pulse.
module shift_word_cnt
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;
  logic          r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (step) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal register: hold, shift, rotate, parallel load,
// sync clear/preset and a per-word shift counter for SERDES use.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1,
  parameter int               CW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             preset,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  mode_t            w_mode;
  logic             w_shr;
  logic             w_shl;
  logic             w_load;
  logic             w_sync;
  logic             w_restart;
  logic             w_step;
  logic             w_in_r;
  logic             w_in_l;

  assign w_mode = mode_t'(mode);
  assign w_sync = clr | preset;

  assign w_shr  = en & (w_mode == MODE_SHR);
  assign w_shl  = en & (w_mode == MODE_SHL);
  assign w_load = en & (w_mode == MODE_LOAD);

  assign w_restart = w_sync | w_load;
  assign w_step    = ~w_sync & (w_shr | w_shl);

  assign w_in_r = rot ? r_q[0]       : sin_r;
  assign w_in_l = rot ? r_q[WIDTH-1] : sin_l;

  always_comb begin
    w_q_nxt = r_q;
    if (clr) begin
      w_q_nxt = '0;
    end else if (preset) begin
      w_q_nxt = PRESET_VAL;
    end else if (en) begin
      unique case (w_mode)
        MODE_HOLD: w_q_nxt = r_q;
        MODE_SHR:  w_q_nxt = {w_in_r, r_q[WIDTH-1:1]};
        MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], w_in_l};
        MODE_LOAD: w_q_nxt = d;
        default:   w_q_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  shift_word_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .restart (w_restart),
    .step    (w_step),
    .cnt     (shift_cnt),
    .done    (word_done)
  );

  assign q      = r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed vector bench for shift_reg_universal at WIDTH=8.
module tb_shift_reg_universal;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic       preset;
  logic [1:0] mode;
  logic       rot;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic [2:0] shift_cnt;
  logic       word_done;

  int n_chk;
  int n_err;

  typedef struct {
    logic       clr;
    logic       pre;
    logic       en;
    logic [1:0] mode;
    logic       rot;
    logic       sl;
    logic       sr;
    logic [7:0] d;
    logic [7:0] eq;
    logic [2:0] ec;
    logic       ed;
  } vec_t;

  vec_t v[$];

  shift_reg_universal #(
    .WIDTH      (8),
    .RESET_VAL  (8'h00),
    .PRESET_VAL (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .preset    (preset),
    .mode      (mode),
    .rot       (rot),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .d         (d),
    .q         (q),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .shift_cnt (shift_cnt),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] eq,
                     input logic [2:0] ec, input logic ed);
    n_chk++;
    if (q !== eq || shift_cnt !== ec || word_done !== ed ||
        sout_r !== eq[0] || sout_l !== eq[7]) begin
      n_err++;
      $display("FAIL %s: q=%h cnt=%0d done=%b sl=%b sr=%b want q=%h cnt=%0d done=%b",
               nm, q, shift_cnt, word_done, sout_l, sout_r, eq, ec, ed);
    end
  endtask

  task automatic drive(input logic c, input logic p, input logic e,
                       input logic [1:0] m, input logic r,
                       input logic sl, input logic sr, input logic [7:0] dd);
    clr = c; preset = p; en = e; mode = m;
    rot = r; sin_l = sl; sin_r = sr; d = dd;
  endtask

  task automatic add(input logic c, input logic p, input logic e,
                     input logic [1:0] m, input logic r, input logic sl,
                     input logic sr, input logic [7:0] dd,
                     input logic [7:0] eq, input logic [2:0] ec,
                     input logic ed);
    vec_t t;
    t.clr = c; t.pre = p; t.en = e; t.mode = m; t.rot = r;
    t.sl = sl; t.sr = sr; t.d = dd;
    t.eq = eq; t.ec = ec; t.ed = ed;
    v.push_back(t);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 8'h00);

    // clr beats preset, regardless of en/mode
    add(1, 1, 1, 2'b11, 0, 0, 0, 8'hA5, 8'h00, 3'd0, 0);
    add(0, 1, 0, 2'b11, 0, 0, 0, 8'hA5, 8'hFF, 3'd0, 0);
    // load A5, shift right 8 with sin_r=0
    add(0, 0, 1, 2'b11, 0, 0, 0, 8'hA5, 8'hA5, 3'd0, 0);
    add(0, 0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h52, 3'd1, 0);
    add(0, 0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h29, 3'd2, 0);
    add(0, 0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h14, 3'd3, 0);
    add(0, 0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h0A, 3'd4, 0);
    add(0, 0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h05, 3'd5, 0);
    add(0, 0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h02, 3'd6, 0);
    add(0, 0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h01, 3'd7, 0);
    add(0, 0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h00, 3'd0, 1);
    add(0, 0, 1, 2'b00, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0);
    // load 81, rotate left 8
    add(0, 0, 1, 2'b11, 0, 0, 0, 8'h81, 8'h81, 3'd0, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'h03, 3'd1, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'h06, 3'd2, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'h0C, 3'd3, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'h18, 3'd4, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'h30, 3'd5, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'h60, 3'd6, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'hC0, 3'd7, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'h81, 3'd0, 1);
    // shl 3, en low 2 cycles, shl 5 with sin_l=1
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h02, 3'd1, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h04, 3'd2, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h08, 3'd3, 0);
    add(0, 0, 0, 2'b10, 0, 1, 0, 8'h00, 8'h08, 3'd3, 0);
    add(0, 0, 0, 2'b10, 0, 1, 0, 8'h00, 8'h08, 3'd3, 0);
    add(0, 0, 1, 2'b10, 0, 1, 0, 8'h00, 8'h11, 3'd4, 0);
    add(0, 0, 1, 2'b10, 0, 1, 0, 8'h00, 8'h23, 3'd5, 0);
    add(0, 0, 1, 2'b10, 0, 1, 0, 8'h00, 8'h47, 3'd6, 0);
    add(0, 0, 1, 2'b10, 0, 1, 0, 8'h00, 8'h8F, 3'd7, 0);
    add(0, 0, 1, 2'b10, 0, 1, 0, 8'h00, 8'h1F, 3'd0, 1);
    // shr 5 with sin_r=1, load mid-word, then 8 shl
    add(0, 0, 1, 2'b01, 0, 0, 1, 8'h00, 8'h8F, 3'd1, 0);
    add(0, 0, 1, 2'b01, 0, 0, 1, 8'h00, 8'hC7, 3'd2, 0);
    add(0, 0, 1, 2'b01, 0, 0, 1, 8'h00, 8'hE3, 3'd3, 0);
    add(0, 0, 1, 2'b01, 0, 0, 1, 8'h00, 8'hF1, 3'd4, 0);
    add(0, 0, 1, 2'b01, 0, 0, 1, 8'h00, 8'hF8, 3'd5, 0);
    add(0, 0, 1, 2'b11, 0, 0, 0, 8'h11, 8'h11, 3'd0, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h22, 3'd1, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h44, 3'd2, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h88, 3'd3, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h10, 3'd4, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h20, 3'd5, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h40, 3'd6, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h80, 3'd7, 0);
    add(0, 0, 1, 2'b10, 0, 0, 0, 8'h00, 8'h00, 3'd0, 1);
    add(0, 0, 1, 2'b00, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0);
    // direction change mid-word keeps counting
    add(0, 0, 1, 2'b11, 0, 0, 0, 8'hC3, 8'hC3, 3'd0, 0);
    add(0, 0, 1, 2'b01, 1, 0, 0, 8'h00, 8'hE1, 3'd1, 0);
    add(0, 0, 1, 2'b01, 1, 0, 0, 8'h00, 8'hF0, 3'd2, 0);
    add(0, 0, 1, 2'b01, 1, 0, 0, 8'h00, 8'h78, 3'd3, 0);
    add(0, 0, 1, 2'b01, 1, 0, 0, 8'h00, 8'h3C, 3'd4, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'h78, 3'd5, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'hF0, 3'd6, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'hE1, 3'd7, 0);
    add(0, 0, 1, 2'b10, 1, 0, 0, 8'h00, 8'hC3, 3'd0, 1);
    // clr with en low, preset mid-word
    add(0, 0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h61, 3'd1, 0);
    add(1, 0, 0, 2'b01, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0);
    add(0, 0, 1, 2'b01, 0, 0, 1, 8'h00, 8'h80, 3'd1, 0);
    add(0, 1, 1, 2'b01, 0, 0, 1, 8'h00, 8'hFF, 3'd0, 0);
    add(0, 0, 1, 2'b00, 0, 0, 0, 8'h00, 8'hFF, 3'd0, 0);

    repeat (2) @(posedge clk);
    #1 chk("reset_state", 8'h00, 3'd0, 0);
    @(negedge clk);
    reset = 1'b1;

    // async reset mid-word, between edges
    drive(0, 0, 1, 2'b11, 0, 0, 0, 8'h3C);
    @(posedge clk); #1;
    chk("load_3c", 8'h3C, 3'd0, 0);
    drive(0, 0, 1, 2'b01, 0, 0, 0, 8'h3C);
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_shift", 8'h0F, 3'd2, 0);
    #2 reset = 1'b0;
    #1 chk("async_rst", 8'h00, 3'd0, 0);
    drive(0, 0, 1, 2'b11, 0, 0, 0, 8'h3C);
    @(posedge clk); #1;
    chk("rst_hold", 8'h00, 3'd0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].clr, v[i].pre, v[i].en, v[i].mode,
            v[i].rot, v[i].sl, v[i].sr, v[i].d);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), v[i].eq, v[i].ec, v[i].ed);
    end

    // back-to-back rotated words: one pulse every 8 cycles
    drive(0, 0, 1, 2'b11, 0, 0, 0, 8'h5A);
    @(posedge clk); #1;
    chk("b2b_load", 8'h5A, 3'd0, 0);
    drive(0, 0, 1, 2'b01, 1, 0, 0, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b%0d", i), (i % 8 == 0) ? 8'h5A : q,
          3'(i % 8), (i % 8 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
